// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - decoder, datapath-enable and data-memory bundle for cpu_sequencer
//   dec_*        : registered control signals from the instruction decoder
//   branch_taken : flag-logic condition result, meaningful in EXEC
//   mem_ack      : data memory access complete
//   ir_load, pc_inc, pc_load, rf_we, wb_sel, alu_latch : datapath enables
//   mem_req, mem_we, mdr_load                          : data memory control
//   master : sequencer side; slave : datapath / memory side
interface cpu_sequencer_if;
  logic dec_reg_write;
  logic dec_mem_read;
  logic dec_mem_write;
  logic dec_mem_to_reg;
  logic dec_branch;
  logic dec_jump;
  logic dec_halt;
  logic branch_taken;
  logic mem_ack;
  logic ir_load;
  logic pc_inc;
  logic pc_load;
  logic rf_we;
  logic wb_sel;
  logic alu_latch;
  logic mem_req;
  logic mem_we;
  logic mdr_load;

  modport master (
    input  dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg,
           dec_branch, dec_jump, dec_halt, branch_taken, mem_ack,
    output ir_load, pc_inc, pc_load, rf_we, wb_sel, alu_latch,
           mem_req, mem_we, mdr_load
  );

  modport slave (
    output dec_reg_write, dec_mem_read, dec_mem_write, dec_mem_to_reg,
           dec_branch, dec_jump, dec_halt, branch_taken, mem_ack,
    input  ir_load, pc_inc, pc_load, rf_we, wb_sel, alu_latch,
           mem_req, mem_we, mdr_load
  );
endinterface

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle control FSM for the MAK-8 CPU
//   clk, rst     : clock, synchronous active-high reset
//   run, step    : continuous execution level / single-instruction pulse
//   bus          : decoder inputs, datapath enables, data-memory handshake
//   halted/fault : sticky HALT / FAULT indication
//   state        : current state encoding for debug LEDs
//   cycle_count  : cycles spent in FETCH..WB
//   instr_count  : retired instructions (HLT included)
module cpu_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  cpu_sequencer_if.master  bus,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6,
    S_FAULT  = 3'd7
  } state_t;

  // Last wait-counter value before giving up on mem_ack.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     cur;
  state_t     nxt;
  logic       f_reg_write;
  logic       f_mem_read;
  logic       f_mem_write;
  logic       f_mem_to_reg;
  logic       f_branch;
  logic       f_jump;
  logic       f_taken;
  logic [7:0] wait_cnt;
  logic       take_pc;

  assign take_pc = f_jump | (f_branch & f_taken);
  assign state   = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur          <= S_IDLE;
      f_reg_write  <= 1'b0;
      f_mem_read   <= 1'b0;
      f_mem_write  <= 1'b0;
      f_mem_to_reg <= 1'b0;
      f_branch     <= 1'b0;
      f_jump       <= 1'b0;
      f_taken      <= 1'b0;
      wait_cnt     <= 8'd0;
      cycle_count  <= '0;
      instr_count  <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_DECODE) begin
        f_reg_write  <= bus.dec_reg_write;
        f_mem_read   <= bus.dec_mem_read;
        f_mem_write  <= bus.dec_mem_write;
        f_mem_to_reg <= bus.dec_mem_to_reg;
        f_branch     <= bus.dec_branch;
        f_jump       <= bus.dec_jump;
      end
      if (cur == S_EXEC) begin
        f_taken  <= bus.branch_taken;
        wait_cnt <= 8'd0;
      end
      if (cur == S_MEM && !bus.mem_ack) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (cur inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB}) begin
        cycle_count <= cycle_count + CNT_W'(1);
      end
      // HLT retires on its way into HALT; everything else retires in WB.
      if (cur == S_WB || (cur == S_DECODE && bus.dec_halt)) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    nxt           = cur;
    bus.ir_load   = 1'b0;
    bus.pc_inc    = 1'b0;
    bus.pc_load   = 1'b0;
    bus.rf_we     = 1'b0;
    bus.wb_sel    = 1'b0;
    bus.alu_latch = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mdr_load  = 1'b0;
    halted        = 1'b0;
    fault         = 1'b0;
    case (cur)
      S_IDLE: begin
        if (run || step) nxt = S_FETCH;
      end
      S_FETCH: begin
        bus.ir_load = 1'b1;
        nxt         = S_DECODE;
      end
      S_DECODE: begin
        nxt = bus.dec_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        bus.alu_latch = 1'b1;
        nxt           = (f_mem_read || f_mem_write) ? S_MEM : S_WB;
      end
      S_MEM: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = f_mem_write;
        if (bus.mem_ack) begin
          // Only output with an input path: read data is captured on the ack cycle.
          bus.mdr_load = f_mem_read;
          nxt          = S_WB;
        end else if (wait_cnt == WAIT_LAST) begin
          nxt = S_FAULT;
        end
      end
      S_WB: begin
        bus.rf_we   = f_reg_write;
        bus.wb_sel  = f_mem_to_reg;
        bus.pc_load = take_pc;
        bus.pc_inc  = ~take_pc;
        nxt         = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed scoreboard bench for cpu_sequencer
module tb_cpu_sequencer;
  localparam int TMO = 15;
  localparam int W   = 16;

  // Decoder word: {reg_write, mem_read, mem_write, mem_to_reg, branch, jump, halt}
  localparam logic [6:0] D_ADD = 7'b100_0000;
  localparam logic [6:0] D_LDB = 7'b110_1000;
  localparam logic [6:0] D_STB = 7'b001_0000;
  localparam logic [6:0] D_BR  = 7'b000_0100;
  localparam logic [6:0] D_JAL = 7'b100_0010;
  localparam logic [6:0] D_HLT = 7'b000_0001;

  logic         clk = 1'b0;
  logic         rst;
  logic         run;
  logic         step;
  logic         halted;
  logic         fault;
  logic [2:0]   state;
  logic [W-1:0] cycle_count;
  logic [W-1:0] instr_count;
  logic [10:0]  outs;

  cpu_sequencer_if bus ();

  cpu_sequencer #(.MEM_TIMEOUT(TMO), .CNT_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .step        (step),
    .bus         (bus),
    .halted      (halted),
    .fault       (fault),
    .state       (state),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  assign outs = {bus.ir_load, bus.pc_inc, bus.pc_load, bus.rf_we, bus.wb_sel, bus.alu_latch,
                 bus.mem_req, bus.mem_we, bus.mdr_load, halted, fault};

  typedef struct {
    logic rf_we;
    logic wb_sel;
    logic pc_load;
    logic pc_inc;
    int   lat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_instr = 0;
  int   exp_cyc   = 0;
  int   mem_cycles;
  int   fetch_wait;
  bit   rf_we_stray;
  bit   step_in_exec;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All sampling and driving happens 1 time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_dec(input logic [6:0] d);
    {bus.dec_reg_write, bus.dec_mem_read, bus.dec_mem_write, bus.dec_mem_to_reg,
     bus.dec_branch, bus.dec_jump, bus.dec_halt} = d;
  endtask

  task automatic wait_fetch();
    fetch_wait = 0;
    while (state !== 3'd1 && fetch_wait < 30) begin
      tick();
      fetch_wait++;
    end
    if (state !== 3'd1) chk("fetch_timeout", 32'(state), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    step = 1'b0;
    bus.mem_ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_instr = 0;
    exp_cyc = 0;
  endtask

  // Runs one instruction from FETCH to WB (or FAULT when ack_wait < 0).
  task automatic do_instr(input logic [6:0] d, input logic taken, input int ack_wait, input string tag);
    exp_t e;
    int   lat;
    bit   is_mem;
    bit   done;
    set_dec(d);
    bus.branch_taken = taken;
    is_mem    = d[5] | d[4];
    e.rf_we   = d[6];
    e.wb_sel  = d[3];
    e.pc_load = d[1] | (d[2] & taken);
    e.pc_inc  = ~e.pc_load;
    e.lat     = is_mem ? 5 + ack_wait : 4;
    if (!(is_mem && ack_wait < 0)) sb.push_back(e);
    wait_fetch();
    chk({tag, "_ir_load"}, 32'(bus.ir_load), 32'd1);
    lat = 0;
    mem_cycles = 0;
    rf_we_stray = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      lat++;
      step = step_in_exec && (state == 3'd3);
      if (state == 3'd4) begin
        bus.mem_ack = (mem_cycles == ack_wait);
        #1;
        chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'd1);
        chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'(d[4]));
        if (bus.mem_ack) chk({tag, "_mdr_load"}, 32'(bus.mdr_load), 32'(d[5]));
        mem_cycles++;
      end else begin
        bus.mem_ack = 1'b0;
      end
      if (state != 3'd5 && bus.rf_we) rf_we_stray = 1'b1;
      if (state == 3'd5) begin
        if (sb.size() == 0) begin
          chk({tag, "_unexpected_wb"}, 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({tag, "_rf_we"}, 32'(bus.rf_we), 32'(e.rf_we));
          chk({tag, "_wb_sel"}, 32'(bus.wb_sel), 32'(e.wb_sel));
          chk({tag, "_pc_load"}, 32'(bus.pc_load), 32'(e.pc_load));
          chk({tag, "_pc_inc"}, 32'(bus.pc_inc), 32'(e.pc_inc));
          chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
          exp_instr++;
          exp_cyc += e.lat;
        end
        done = 1'b1;
        break;
      end
      if (state == 3'd7) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) chk({tag, "_no_completion"}, 32'(state), 32'd5);
    bus.mem_ack = 1'b0;
    step = 1'b0;
  endtask

  initial begin
    set_dec(7'd0);
    bus.branch_taken = 1'b0;
    step_in_exec = 1'b0;
    do_reset();

    // Reset state
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_cycle_count", 32'(cycle_count), 32'd0);
    chk("reset_instr_count", 32'(instr_count), 32'd0);

    // Three back-to-back ADDs with run held
    run = 1'b1;
    do_instr(D_ADD, 1'b0, 0, "add0");
    do_instr(D_ADD, 1'b0, 0, "add1");
    chk("add1_refetch_gap", 32'(fetch_wait), 32'd1);
    do_instr(D_ADD, 1'b0, 0, "add2");
    chk("add2_refetch_gap", 32'(fetch_wait), 32'd1);
    run = 1'b0;
    tick();
    chk("add_idle", 32'(state), 32'd0);
    chk("add_instr_count", 32'(instr_count), 32'd3);
    chk("add_cycle_count", 32'(cycle_count), 32'd12);

    // Load with ack two cycles late
    run = 1'b1;
    do_instr(D_LDB, 1'b0, 2, "ldb");
    chk("ldb_mem_cycles", 32'(mem_cycles), 32'd3);

    // Branch taken / not taken, then JAL
    do_instr(D_BR, 1'b1, 0, "br_taken");
    do_instr(D_BR, 1'b0, 0, "br_not");
    do_instr(D_JAL, 1'b0, 0, "jal");
    run = 1'b0;
    tick();
    chk("jal_idle", 32'(state), 32'd0);
    chk("pre_step_instr_count", 32'(instr_count), 32'(exp_instr));
    chk("pre_step_cycle_count", 32'(cycle_count), 32'(exp_cyc));

    // Single stepping, with a stray step pulse during EXEC
    step_in_exec = 1'b1;
    step = 1'b1;
    do_instr(D_ADD, 1'b0, 0, "step0");
    step_in_exec = 1'b0;
    repeat (10) tick();
    chk("step0_idle", 32'(state), 32'd0);
    chk("step0_instr_count", 32'(instr_count), 32'(exp_instr));
    step = 1'b1;
    do_instr(D_ADD, 1'b0, 0, "step1");
    repeat (10) tick();
    chk("step1_idle", 32'(state), 32'd0);
    chk("step1_instr_count", 32'(instr_count), 32'(exp_instr));
    chk("step1_cycle_count", 32'(cycle_count), 32'(exp_cyc));

    // Store that never gets an ack
    run = 1'b1;
    do_instr(D_STB, 1'b0, -1, "stb_tmo");
    chk("stb_state", 32'(state), 32'd7);
    chk("stb_fault", 32'(fault), 32'd1);
    chk("stb_mem_cycles", 32'(mem_cycles), 32'(TMO));
    chk("stb_rf_we_stray", 32'(rf_we_stray), 32'd0);
    chk("stb_instr_count", 32'(instr_count), 32'(exp_instr));
    chk("stb_cycle_count", 32'(cycle_count), 32'(exp_cyc + 3 + TMO));
    run = 1'b0;
    repeat (3) tick();
    run = 1'b1;
    repeat (3) tick();
    chk("fault_sticky", 32'(state), 32'd7);
    chk("fault_outs", 32'(outs), 32'd1);
    chk("fault_cycle_frozen", 32'(cycle_count), 32'(exp_cyc + 3 + TMO));
    do_reset();
    chk("fault_rst_state", 32'(state), 32'd0);
    chk("fault_rst_cycle", 32'(cycle_count), 32'd0);
    chk("fault_rst_instr", 32'(instr_count), 32'd0);

    // Halt
    run = 1'b1;
    set_dec(D_HLT);
    wait_fetch();
    tick();
    tick();
    chk("hlt_state", 32'(state), 32'd6);
    chk("hlt_halted", 32'(halted), 32'd1);
    chk("hlt_instr_count", 32'(instr_count), 32'd1);
    chk("hlt_no_pc", 32'({bus.pc_inc, bus.pc_load}), 32'd0);
    run = 1'b0;
    repeat (3) tick();
    run = 1'b1;
    repeat (3) tick();
    chk("hlt_sticky", 32'(state), 32'd6);
    chk("hlt_cycle_frozen", 32'(cycle_count), 32'd2);
    do_reset();

    // Reset in the middle of a memory handshake
    run = 1'b1;
    set_dec(D_LDB);
    wait_fetch();
    for (int i = 0; i < 10 && state != 3'd4; i++) tick();
    chk("midmem_reached", 32'(state), 32'd4);
    tick();
    rst = 1'b1;
    tick();
    chk("midmem_rst_state", 32'(state), 32'd0);
    chk("midmem_rst_outs", 32'(outs), 32'd0);
    chk("midmem_rst_counts", 32'({cycle_count, instr_count}), 32'd0);
    rst = 1'b0;
    run = 1'b0;

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control FSM for the MAK-8 CPU. Sequences each instruction through fetch, decode, execute, an optional data-memory access and write-back. It consumes the registered control signals from the instruction decoder and produces per-cycle enables for the PC, IR, register file and data memory. It also provides run/step control, a data-memory handshake with timeout, and performance counters for board debug.

Parameters:
MEM_TIMEOUT, 15, max cycles in MEM waiting for mem_ack before FAULT (1..255).
CNT_W, 16, width of cycle_count and instr_count.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
run  input  1  level; continuous execution while high
step  input  1  single-cycle pulse; execute exactly one instruction from IDLE
dec_reg_write  input  1  decoder: instruction writes rd
dec_mem_read  input  1  decoder: load
dec_mem_write  input  1  decoder: store
dec_mem_to_reg  input  1  decoder: write-back source is memory
dec_branch  input  1  decoder: conditional branch
dec_jump  input  1  decoder: JMP/JAL
dec_halt  input  1  decoder: HLT
branch_taken  input  1  condition result from flag logic, valid in EXEC
mem_ack  input  1  data memory access complete
ir_load  output  1  latch ROM output into IR
pc_inc  output  1  PC <= PC+1
pc_load  output  1  PC <= branch/jump target
rf_we  output  1  register file write enable
wb_sel  output  1  0=ALU result, 1=memory data
alu_latch  output  1  latch ALU result / address register
mem_req  output  1  data memory request
mem_we  output  1  1=store, 0=load (qualified by mem_req)
mdr_load  output  1  latch memory read data
halted  output  1  CPU in HALT
fault  output  1  CPU in FAULT (memory timeout)
state  output  3  current state encoding (debug LEDs)
cycle_count  output  CNT_W  active cycle counter
instr_count  output  CNT_W  retired instruction counter

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Reset (rst=1 at clk edge): state=IDLE; latched flags, wait counter, cycle_count and instr_count cleared. All outputs 0. Reset overrides every state, including MEM mid-handshake, HALT and FAULT.
- IDLE: if run or step -> FETCH, else stay.
- FETCH: ir_load=1 -> DECODE.
- DECODE: latch all dec_* into internal flags. If dec_halt -> HALT. Otherwise -> EXEC.
- EXEC: alu_latch=1; latch branch_taken. If mem_read or mem_write flag -> MEM (wait counter=0). Otherwise -> WB.
- MEM:
  - mem_req=1 and mem_we=mem_write flag for every cycle in MEM.
  - On mem_ack=1: mdr_load=mem_read flag (combinational, same cycle) -> WB.
  - Otherwise wait counter +1. When the counter reaches MEM_TIMEOUT without ack -> FAULT.
  - mem_ack is ignored outside MEM.
- WB (exactly one cycle):
  - rf_we=reg_write flag; wb_sel=mem_to_reg flag.
  - pc_load=jump or (branch and latched taken); pc_inc=not pc_load. Exactly one of the two is 1.
  - instr_count+1.
  - Next state: FETCH if run=1, else IDLE.
- HALT: halted=1. On entry instr_count+1 (HLT retires). PC is not updated. Sticky until rst.
- FAULT: fault=1. No enables asserted. Sticky until rst. The faulting instruction does not retire.
- Latency: ALU/branch/jump instruction = 4 cycles (FETCH..WB). Load/store = 5 + N cycles, where N = ack wait cycles.
- Run/step:
  - Deasserting run mid-instruction completes the current instruction, then enters IDLE.
  - step is ignored outside IDLE.
  - With run=0, each step pulse retires exactly one instruction.
  - run and step both high in IDLE behaves as run.
- cycle_count +1 every cycle in states FETCH..WB. Frozen in IDLE, HALT and FAULT. Both counters wrap modulo 2^CNT_W.
- state output equals the current state register. All outputs except mdr_load are functions of registered state/flags only (no input-to-output combinational path).

Test Plan:
- R-type ADD, run=1: ir_load at cycle 1, rf_we=1 with pc_inc=1 at cycle 4, ir_load again at cycle 5; after 3 instructions instr_count=3, cycle_count=12.
- LDB with mem_ack delayed 2 cycles: mem_req high 3 cycles, mem_we=0, mdr_load=1 on ack cycle, next cycle WB with rf_we=1 and wb_sel=1; total 7 cycles.
- STB with no ack, MEM_TIMEOUT=15: after 15 MEM cycles state=7, fault=1, rf_we never asserted, instr_count unchanged; rst returns state=0 and clears all counters.
- Branch with branch_taken=1 gives pc_load=1, pc_inc=0 in WB; same with branch_taken=0 gives pc_inc=1; JAL (dec_jump=1, dec_reg_write=1) gives pc_load=1 and rf_we=1.
- run=0, two step pulses 10 cycles apart: each retires exactly one instruction then returns to IDLE; step pulse during EXEC is ignored.
- HLT at run: state=6 after DECODE, halted=1, instr_count+1, no pc_inc/pc_load; run toggling has no effect; rst asserted mid-MEM yields all outputs 0 the next cycle.
